// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexes a 4-digit BCD word onto a 4-anode, 8-cathode
//   7-segment display. Each digit slot starts with a blanking window
//   (all anodes off) to stop ghosting between digits. It also handles
//   per-digit blinking, leading-zero suppression, and tear-free updates:
//   the displayed value only changes at the end of a frame.
//
//   Ports
//     clk_osc     system oscillator clock
//     resetn      asynchronous active-low reset
//     num_in      BCD digits, [15:12] = digit 3 (leftmost) .. [3:0] = digit 0
//     num_valid   1-cycle capture strobe for num_in (last strobe in a frame wins)
//     blink_mask  bit i = 1: digit i blinks
//     dp_mask     bit i = 1: decimal point lit on digit i
//     lz_en       1 = suppress leading zeros on digits 3..1
//     enable      0 = display dark, scan held at digit 0 / BLANK
//     anode       active-low digit enables, bit i = digit i (registered)
//     seg_n       active-low cathodes {dp,g,f,e,d,c,b,a} (registered)
//     frame_done  high during the last cycle of the digit-3 slot
module seg_scan_driver #(
  parameter int DIGIT_TICKS = 65536,
  parameter int BLANK_TICKS = 512,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic        clk_osc,
  input  logic        resetn,
  input  logic [15:0] num_in,
  input  logic        num_valid,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  input  logic        enable,
  output logic [3:0]  anode,
  output logic [7:0]  seg_n,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(DIGIT_TICKS + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [1:0]         digit_q, digit_d;
  logic [15:0]        pending_q, display_q;
  logic [BLK_W-1:0]   blink_cnt_q;
  logic               blink_phase_q;
  logic [3:0]         anode_d;
  logic [7:0]         seg_n_d;
  logic               slot_last;
  logic               boundary;
  logic [3:0]         cur_bcd;
  logic               dark;

  // Active-high segments g..a; anything outside 0..9 is shown as a dash.
  function automatic logic [6:0] decode7(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 is always shown so that a zero value still reads "0".
  function automatic logic lead_zero(input logic [15:0] disp, input logic [1:0] idx);
    logic lz;
    case (idx)
      2'd3:    lz = (disp[15:12] == 4'd0);
      2'd2:    lz = (disp[15:8]  == 8'd0);
      2'd1:    lz = (disp[15:4]  == 12'd0);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction

  assign slot_last  = (slot_cnt_q == CNT_W'(DIGIT_TICKS - 1));
  assign boundary   = enable && slot_last && (digit_q == 2'd3);
  assign frame_done = boundary;

  // ---- scan FSM: state register ----
  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_BLANK;
      slot_cnt_q <= '0;
      digit_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      digit_q    <= digit_d;
    end
  end

  // ---- scan FSM: next state ----
  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    digit_d    = digit_q;
    if (!enable) begin
      state_d    = ST_BLANK;
      slot_cnt_d = '0;
      digit_d    = 2'd0;
    end else if (slot_last) begin
      state_d    = ST_BLANK;
      slot_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
      if (state_q == ST_BLANK && slot_cnt_q == CNT_W'(BLANK_TICKS - 1))
        state_d = ST_DRIVE;
    end
  end

  // ---- scan FSM: outputs (registered one cycle later) ----
  assign cur_bcd = display_q[{digit_q, 2'b00} +: 4];
  assign dark    = (blink_mask[digit_q] && blink_phase_q) ||
                   (lz_en && lead_zero(display_q, digit_q));

  // Dark digits also release the cathodes so nothing is driven on them.
  always_comb begin
    anode_d = 4'b1111;
    seg_n_d = 8'hFF;
    if (enable && state_q == ST_DRIVE && !dark) begin
      anode_d = ~(4'b0001 << digit_q);
      seg_n_d = {~dp_mask[digit_q], ~decode7(cur_bcd)};
    end
  end

  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      anode <= 4'b1111;
      seg_n <= 8'hFF;
    end else begin
      anode <= anode_d;
      seg_n <= seg_n_d;
    end
  end

  // ---- value capture ----
  // While disabled nothing is visible, so display tracks pending freely;
  // otherwise it only moves at the frame boundary. A strobe in the update
  // cycle bypasses pending so that value is not a frame late.
  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      pending_q <= 16'd0;
      display_q <= 16'd0;
    end else begin
      if (num_valid)
        pending_q <= num_in;
      if (!enable || boundary)
        display_q <= num_valid ? num_in : pending_q;
    end
  end

  // ---- blink phase, free running ----
  always_ff @(posedge clk_osc or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;
  localparam int DT = 16;
  localparam int BT = 4;
  localparam int BH = 128;
  localparam int FR = 4 * DT;

  logic        clk_osc = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] num_in = 16'd0;
  logic        num_valid = 1'b0;
  logic [3:0]  blink_mask = 4'd0;
  logic [3:0]  dp_mask = 4'd0;
  logic        lz_en = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  anode;
  logic [7:0]  seg_n;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_pos;
  int          m_cyc;
  logic [15:0] m_pend;
  logic [15:0] m_disp;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;

  seg_scan_driver #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT), .BLINK_HALF(BH)) dut (
    .clk_osc(clk_osc), .resetn(resetn), .num_in(num_in), .num_valid(num_valid),
    .blink_mask(blink_mask), .dp_mask(dp_mask), .lz_en(lz_en), .enable(enable),
    .anode(anode), .seg_n(seg_n), .frame_done(frame_done)
  );

  always #5 clk_osc = ~clk_osc;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] an;   // {digit3..digit0}
    logic [31:0] seg;  // {digit3..digit0}
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] seg_of(input logic [3:0] v, input logic dp);
    logic [6:0] g;
    case (v)
      4'd0: g = 7'h3F; 4'd1: g = 7'h06; 4'd2: g = 7'h5B; 4'd3: g = 7'h4F;
      4'd4: g = 7'h66; 4'd5: g = 7'h6D; 4'd6: g = 7'h7D; 4'd7: g = 7'h07;
      4'd8: g = 7'h7F; 4'd9: g = 7'h6F; default: g = 7'h40;
    endcase
    return {~dp, ~g};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cyc = 0; m_pend = 16'd0; m_disp = 16'd0;
  endtask

  // Expected output after this edge from the pre-edge model state, then advance.
  task automatic model_edge();
    int d, w;
    logic ph, lz;
    logic [3:0] v;
    d  = m_pos / DT;
    w  = m_pos % DT;
    ph = ((m_cyc / BH) % 2) == 1;
    v  = 4'((m_disp >> (4 * d)) & 16'hF);
    lz = lz_en && ((d == 3 && m_disp[15:12] == 0) || (d == 2 && m_disp[15:8] == 0) ||
                   (d == 1 && m_disp[15:4] == 0));
    e_an = 4'hF; e_seg = 8'hFF;
    if (enable && w >= BT && !(blink_mask[d] && ph) && !lz) begin
      e_an  = ~(4'b0001 << d);
      e_seg = seg_of(v, dp_mask[d]);
    end
    if (!enable || m_pos == FR - 1) m_disp = num_valid ? num_in : m_pend;
    if (num_valid) m_pend = num_in;
    m_pos = enable ? (m_pos + 1) % FR : 0;
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk_osc);
    model_edge();
    #1;
    check("anode", {28'd0, anode}, {28'd0, e_an});
    check("seg_n", {24'd0, seg_n}, {24'd0, e_seg});
    check("frame_done", {31'd0, frame_done}, {31'd0, (enable && m_pos == FR - 1)});
    num_valid = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] v);
    num_in = v; num_valid = 1'b1;
    step();
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_pos != target && n < 500) begin
      step();
      n++;
    end
    check("run_to_timeout", m_pos, target);
  endtask

  initial begin
    logic [15:0] rv;
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h7BDE, 32'hF9A4B099};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, 16'hFFFE, 32'hFFFFFF92};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'hFFFE, 32'hFFFFFFC0};
    vecs[3] = '{16'h00A0, 4'b0100, 1'b0, 16'h7BDE, 32'hC040BFC0};
    vecs[4] = '{16'h0780, 4'b0001, 1'b1, 16'hFBDE, 32'hFFF88040};
    vecs[5] = '{16'h0809, 4'b0000, 1'b1, 16'hFBDE, 32'hFF80C090};

    // reset state
    @(posedge clk_osc); #1;
    check("rst_anode", {28'd0, anode}, 32'hF);
    check("rst_seg_n", {24'd0, seg_n}, 32'hFF);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    resetn = 1'b1;
    model_reset();

    // table-driven digit content
    for (int i = 0; i < 6; i++) begin
      dp_mask = vecs[i].dp;
      lz_en   = vecs[i].lz;
      strobe(vecs[i].num);
      run_to(0);
      for (int d = 0; d < 4; d++) begin
        run_to(d * DT + BT + 3);
        check($sformatf("vec%0d_anode_d%0d", i, d), {28'd0, anode}, {28'd0, vecs[i].an[4*d +: 4]});
        check($sformatf("vec%0d_seg_d%0d", i, d), {24'd0, seg_n}, {24'd0, vecs[i].seg[8*d +: 8]});
      end
    end
    dp_mask = 4'd0; lz_en = 1'b0;

    // last strobe in a frame wins
    run_to(5);
    strobe(16'h1111);
    step();
    strobe(16'h2222);
    run_to(0);
    run_to(BT + 3);
    check("last_wins_seg", {24'd0, seg_n}, 32'hA4);

    // strobe coinciding with frame_done is bypassed into the next frame
    run_to(FR - 1);
    check("fd_pulse", {31'd0, frame_done}, 32'd1);
    strobe(16'h9876);
    run_to(BT + 3);
    check("bypass_anode", {28'd0, anode}, 32'hE);
    check("bypass_seg", {24'd0, seg_n}, 32'h82);

    // blink on digit 1 across several blink half-periods
    blink_mask = 4'b0010;
    strobe(16'h5959);
    for (int k = 0; k < 600; k++) step();
    blink_mask = 4'b0000;

    // enable deasserted mid-slot; capture while disabled; restart at digit 0
    run_to(DT + 7);
    enable = 1'b0;
    step();
    check("dis_anode", {28'd0, anode}, 32'hF);
    check("dis_seg", {24'd0, seg_n}, 32'hFF);
    strobe(16'h4321);
    for (int k = 0; k < 70; k++) step();
    enable = 1'b1;
    step();
    run_to(BT + 3);
    check("reen_anode", {28'd0, anode}, 32'hE);
    check("reen_seg", {24'd0, seg_n}, 32'hF9);

    // asynchronous reset in the middle of a DRIVE phase
    run_to(2 * DT + 8);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_anode", {28'd0, anode}, 32'hF);
    check("async_rst_seg", {24'd0, seg_n}, 32'hFF);
    check("async_rst_fd", {31'd0, frame_done}, 32'd0);
    @(posedge clk_osc); #1 resetn = 1'b1;
    model_reset();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 16 == 0) begin
        rv = 16'($urandom);
        for (int j = 0; j < 4; j++) if ($urandom % 3 == 0) rv[4*j +: 4] = 4'd0;
        num_in = rv;
        num_valid = 1'b1;
      end
      if ($urandom % 97 == 0) begin
        blink_mask = 4'($urandom);
        dp_mask    = 4'($urandom);
        lz_en      = 1'($urandom);
      end
      if ($urandom % 150 == 0) enable = ~enable;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
